// File: rtl/vram_sprite_write_arbiter_pkg.sv
// Shared definitions for the sprite VRAM write arbiter.
//   VRAM_ADDR_W / VRAM_DATA_W : width of the pixel-pair address and data words
//   state_t                   : arbiter FSM state (IDLE between bursts, BURST inside one)
package vram_sprite_write_arbiter_pkg;

  localparam int VRAM_ADDR_W = 15;
  localparam int VRAM_DATA_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/vram_write_fifo.sv
// Synchronous show-ahead FIFO holding queued CPU writes.
//   clk, reset   : clock and synchronous active-high flush
//   i_push       : write i_push_data (ignored while full)
//   i_pop        : drop the head entry (ignored while empty)
//   o_pop_data   : head entry, valid whenever o_empty is low
//   o_full       : all DEPTH entries occupied
//   o_empty      : no entries
module vram_write_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full     = (r_count == CNT_FULL);
  assign o_empty    = (r_count == '0);
  assign w_do_push  = i_push && !o_full;
  assign w_do_pop   = i_pop && !o_empty;
  // Show-ahead: the head word is visible without a read request.
  assign o_pop_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vram_sprite_write_arbiter.sv
// Arbitrates CPU pixel writes (buffered in a small FIFO) against DMA sprite
// bursts onto a single registered VRAM write port.
//   clk, reset                          : clock and synchronous active-high reset
//   cpu_valid/cpu_ready, cpu_addr/data  : CPU write handshake and payload
//   dma_valid/dma_ready, dma_addr/data,
//   dma_last                            : DMA beat handshake, payload, final-beat flag
//   vram_write_addr/data/enable         : registered VRAM write port (1-cycle enable)
//   busy                                : burst open or CPU writes still queued
module vram_sprite_write_arbiter
  import vram_sprite_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BURST  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_valid,
  output logic                   cpu_ready,
  input  logic [VRAM_ADDR_W-1:0] cpu_addr,
  input  logic [VRAM_DATA_W-1:0] cpu_data,
  input  logic                   dma_valid,
  output logic                   dma_ready,
  input  logic [VRAM_ADDR_W-1:0] dma_addr,
  input  logic [VRAM_DATA_W-1:0] dma_data,
  input  logic                   dma_last,
  output logic [VRAM_ADDR_W-1:0] vram_write_addr,
  output logic [VRAM_DATA_W-1:0] vram_write_data,
  output logic                   vram_write_enable,
  output logic                   busy
);

  localparam int          ENTRY_W = VRAM_ADDR_W + VRAM_DATA_W;
  localparam logic [7:0]  MAX_CNT = 8'(MAX_BURST);

  state_t                 r_state;
  logic [7:0]             r_beat_count;
  logic                   r_rr_cpu;     // 1: CPU wins the next IDLE contention
  logic                   r_run;        // low during reset and its first edge
  logic [VRAM_ADDR_W-1:0] r_wr_addr;
  logic [VRAM_DATA_W-1:0] r_wr_data;
  logic                   r_wr_en;

  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [ENTRY_W-1:0] w_fifo_head;
  logic               w_cpu_push;
  logic               w_pop;
  logic               w_dma_ready;
  logic               w_dma_fire;

  // r_run keeps both readies low while reset is held, from registered state only.
  assign cpu_ready  = r_run && !w_fifo_full;
  assign w_cpu_push = cpu_valid && cpu_ready;
  assign dma_ready  = w_dma_ready;
  assign w_dma_fire = dma_valid && w_dma_ready;
  assign busy       = (r_state == BURST) || !w_fifo_empty;

  assign vram_write_addr   = r_wr_addr;
  assign vram_write_data   = r_wr_data;
  assign vram_write_enable = r_wr_en;

  vram_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_cpu_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_cpu_push),
    .i_push_data ({cpu_addr, cpu_data}),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  // Grant decision: at most one of w_pop / w_dma_ready per cycle.
  always_comb begin
    w_pop       = 1'b0;
    w_dma_ready = 1'b0;
    if (r_run) begin
      case (r_state)
        IDLE: begin
          if (!w_fifo_empty && (!dma_valid || r_rr_cpu)) w_pop = 1'b1;
          else if (dma_valid)                            w_dma_ready = 1'b1;
        end
        BURST: begin
          // Forced CPU slot once the burst has run MAX_BURST beats.
          if (r_beat_count == MAX_CNT && !w_fifo_empty) w_pop = 1'b1;
          else                                          w_dma_ready = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_beat_count <= '0;
      r_rr_cpu     <= 1'b1;
      r_run        <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_en      <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_wr_en <= w_pop || w_dma_fire;
      if (w_pop) begin
        {r_wr_addr, r_wr_data} <= w_fifo_head;
        r_rr_cpu               <= 1'b0;
      end else if (w_dma_fire) begin
        r_wr_addr <= dma_addr;
        r_wr_data <= dma_data;
        r_rr_cpu  <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_dma_fire && !dma_last) begin
            r_state      <= BURST;
            r_beat_count <= 8'd1;
          end
        end
        BURST: begin
          if (w_pop) begin
            r_beat_count <= '0;
          end else if (w_dma_fire) begin
            if (dma_last) begin
              r_state      <= IDLE;
              r_beat_count <= '0;
            end else if (r_beat_count != MAX_CNT) begin
              r_beat_count <= r_beat_count + 8'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vram_sprite_write_arbiter.md
VRAM_SPRITE_WRITE_ARBITER -- requirements
Module: vram_sprite_write_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: CPU write FIFO entries, power of two, 2..16.
REQ-002 Parameter MAX_BURST, default 32: consecutive DMA beats allowed before a CPU slot is forced, 1..255.
REQ-003 Port clk, input, 1: single clock for all logic.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Ports cpu_valid / cpu_ready, input / output, 1 each: CPU write handshake.
REQ-006 Ports cpu_addr / cpu_data, input, 15 / 16: CPU pixel-pair address and data.
REQ-007 Ports dma_valid / dma_ready, input / output, 1 each: DMA beat handshake.
REQ-008 Ports dma_addr / dma_data / dma_last, input, 15 / 16 / 1: DMA beat address, data and final-beat flag.
REQ-009 Ports vram_write_addr / vram_write_data / vram_write_enable, output, 15 / 16 / 1: registered sprite VRAM write port.
REQ-010 Port busy, output, 1: high when a DMA burst is open or the CPU FIFO is non-empty.

Function
REQ-011 A transfer occurs on a clk edge where valid and ready are both high; payload SHALL be held by the requester until then.
REQ-012 cpu_ready SHALL equal "FIFO not full", derived from registered state only; a push when full SHALL be impossible.
REQ-013 A simultaneous push and pop on a full FIFO SHALL NOT occur, since cpu_ready is low when full.
REQ-014 At most one VRAM write is issued per cycle; the selected payload is registered onto the vram_write_* outputs the following cycle, with vram_write_enable high for exactly that one cycle.
REQ-015 DMA latency: a beat accepted at edge N SHALL appear on the VRAM port in cycle N+1.
REQ-016 CPU latency: a write accepted at edge N SHALL be poppable no earlier than edge N+1 and appear on the VRAM port no earlier than cycle N+2.
REQ-017 The FSM has two states, IDLE and BURST.
REQ-018 In IDLE with only the FIFO non-empty, the block SHALL pop the FIFO.
REQ-019 In IDLE with only dma_valid high, the block SHALL assert dma_ready.
REQ-020 In IDLE with both the FIFO non-empty and dma_valid high, the block SHALL grant the requester not granted last (round-robin); after reset, CPU is granted first.
REQ-021 In IDLE, an accepted DMA beat with dma_last=0 SHALL move the FSM to BURST and set beat_count to 1.
REQ-022 In IDLE, an accepted DMA beat with dma_last=1 (single-beat burst) SHALL leave the FSM in IDLE.
REQ-023 In BURST, dma_ready SHALL be high except in a forced CPU slot.
REQ-024 A forced CPU slot occurs when beat_count equals MAX_BURST and the FIFO is non-empty: dma_ready low, one FIFO pop, beat_count cleared to 0, FSM stays in BURST.
REQ-025 In BURST, if beat_count equals MAX_BURST and the FIFO is empty, the burst SHALL continue with beat_count saturating.
REQ-026 In BURST, each accepted beat SHALL increment beat_count; an accepted beat with dma_last=1 SHALL move the FSM to IDLE.
REQ-027 In BURST with dma_valid low, no write SHALL be issued unless a forced CPU slot applies; the FSM SHALL remain in BURST.
REQ-028 Addresses and data SHALL pass unmodified; address wrap-around is the requester's responsibility.
REQ-029 FIFO order SHALL be strictly preserved; no CPU write is dropped or duplicated.

Reset
REQ-030 While reset is high: FSM to IDLE; FIFO flushed; beat_count 0; round-robin pointer to CPU.
REQ-031 While reset is high: vram_write_enable, vram_write_addr, vram_write_data, cpu_ready, dma_ready and busy SHALL all be 0.
REQ-032 Reset asserted mid-burst SHALL abandon the burst; there is no write-enable pulse in the cycle following reset.
REQ-033 cpu_ready SHALL rise in the first cycle after reset deasserts.

Structure
REQ-034 A shared package SHALL hold VRAM_ADDR_W=15, VRAM_DATA_W=16 and the FSM state enum (IDLE, BURST).
REQ-035 The CPU FIFO SHALL be one sub-module, vram_write_fifo: synchronous, show-ahead, with full/empty flags and parameterised depth and width.

Verification
REQ-036 Single CPU write (0x1234, 0xBEEF) at idle -> vram_write_enable pulses once, 2 cycles later, with addr 0x1234 and data 0xBEEF.
REQ-037 DMA burst of 8 beats (addr 0x0000..0x0007, last on beat 8), no CPU traffic -> 8 back-to-back writes, each 1 cycle after acceptance; FSM returns to IDLE.
REQ-038 MAX_BURST=4, 10-beat DMA burst, 2 CPU writes queued at burst start -> writes are DMA x4, CPU, DMA x4, CPU, DMA x2, with dma_ready low in both CPU slots.
REQ-039 5 CPU writes pushed back-to-back with FIFO_DEPTH=4 and DMA active -> cpu_ready low while full, all 5 written in order, none lost.
REQ-040 Reset asserted after beat 3 of a 6-beat burst, with 2 CPU entries queued -> next cycle all outputs 0, FIFO empty, busy 0, no further writes.
REQ-041 CPU and DMA both pending continuously at IDLE with single-beat DMA bursts -> grants alternate CPU, DMA, CPU, DMA.
